// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   Serial UART receiver for 8N1 frames. The data is sent LSB first and the
//   line idles high. The asynchronous line is synchronised with two flops.
//   A falling edge is qualified by sampling again at the centre of the start
//   bit. Each data bit is sampled at its own centre, and the stop bit is
//   checked at its centre. A received byte is offered on a valid/ready
//   handshake. A bad stop bit gives a one-cycle frame_err pulse. A good byte
//   that arrives while the previous byte is still held gives a one-cycle
//   overrun pulse.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous reset, active low
//   rx_in      serial data in (asynchronous to clk, idle high)
//   rx_data    last accepted byte, stable while rx_valid is high
//   rx_valid   rx_data holds a byte that has not been consumed yet
//   rx_ready   consumer takes rx_data on an edge where rx_valid && rx_ready
//   rx_busy    receiver is not idle
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: good byte dropped because rx_valid was held
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_FRQ   = 27000000,
   parameter int BAUD_RATE = 921600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rx_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CYCLE = CLK_FRQ / BAUD_RATE;
   localparam int HALF  = CYCLE / 2;
   localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);
   localparam logic [15:0] HALF_LAST  = 16'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        rx_meta_q, rx_s_q;
   logic [15:0] cycle_cnt_q, cycle_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_buf_q, shift_buf_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        overrun_q, overrun_d;

   logic        half_tick;
   logic        bit_tick;
   logic        good_stop;
   logic        bad_stop;
   logic        load;

   // Sample instants.
   // half_tick marks the centre of the start bit, counted from the edge detect.
   // bit_tick marks one full bit period after the previous centre.
   assign half_tick = (cycle_cnt_q == HALF_LAST);
   assign bit_tick  = (cycle_cnt_q == CYCLE_LAST);
   assign good_stop = (state_q == S_STOP) && bit_tick &&  rx_s_q;
   assign bad_stop  = (state_q == S_STOP) && bit_tick && !rx_s_q;

   // A good byte can load if the holding register is empty. It can also load
   // if the held byte is consumed on this same edge.
   assign load = good_stop && (!rx_valid_q || rx_ready);

   // ---------------------------------------------------------------------------
   // State register and all other flops
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         cycle_cnt_q <= '0;
         bit_cnt_q   <= '0;
         shift_buf_q <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_in;
         rx_s_q      <= rx_meta_q;
         cycle_cnt_q <= cycle_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_buf_q <= shift_buf_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) state_d = S_START;
         end
         S_START: begin
            // A line that is high again at the centre was a glitch.
            if (half_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (bit_tick && (bit_cnt_q == 4'd7)) state_d = S_STOP;
         end
         S_STOP: begin
            // Leave S_STOP at the stop-bit centre. This leaves half a bit to
            // catch the start edge of the next frame.
            if (bit_tick) state_d = rx_s_q ? S_IDLE : S_BREAK;
         end
         S_BREAK: begin
            // Hold here while the line is low so a break cannot start frames.
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      cycle_cnt_d = '0;
      bit_cnt_d   = bit_cnt_q;
      shift_buf_d = shift_buf_q;

      if (state_d == state_q) begin
         case (state_q)
            S_START, S_STOP: cycle_cnt_d = cycle_cnt_q + 16'd1;
            // The counter restarts at every bit centre inside the data phase.
            S_DATA:          cycle_cnt_d = bit_tick ? 16'd0 : cycle_cnt_q + 16'd1;
            default:         cycle_cnt_d = '0;
         endcase
      end

      if ((state_q == S_START) && (state_d == S_DATA)) begin
         bit_cnt_d = '0;
      end else if ((state_q == S_DATA) && bit_tick) begin
         bit_cnt_d   = bit_cnt_q + 4'd1;
         shift_buf_d = {rx_s_q, shift_buf_q[7:1]};
      end

      rx_data_d   = load ? shift_buf_q : rx_data_q;
      rx_valid_d  = load || (rx_valid_q && !rx_ready);
      overrun_d   = good_stop && rx_valid_q && !rx_ready;
      frame_err_d = bad_stop;
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed and randomised bench for uart_rx at the default rates (29 clk/bit).
//   A frame-level reference model predicts the accepted bytes and counts the
//   expected error pulses. A negedge monitor records handshakes and pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CLK_FRQ   = 27000000;
   localparam int BAUD_RATE = 921600;
   localparam int CYCLE     = CLK_FRQ / BAUD_RATE;
   localparam int HALF      = CYCLE / 2;
   // rx_in edge to visible rx_valid: 2 synchroniser flops, then the receive path.
   localparam int LATENCY   = 2 + HALF + 9 * CYCLE + 1;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rx_in;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   // Monitor state
   int         cyc        = 0;
   int         fe_cnt     = 0;
   int         ov_cnt     = 0;
   int         both_cnt   = 0;
   int         vcyc       = 0;
   int         rise_cyc   = 0;
   logic       valid_prev = 1'b0;
   logic [7:0] got_q[$];

   // Reference model state
   logic [7:0] exp_q[$];
   logic       model_valid = 1'b0;
   logic [7:0] model_data  = 8'h00;
   int         rd_idx      = 0;

   uart_rx #(.CLK_FRQ(CLK_FRQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx_in     (rx_in),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_busy   (rx_busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (frame_err && overrun) both_cnt <= both_cnt + 1;
      if (rx_valid) vcyc <= vcyc + 1;
      if (rx_valid && !valid_prev) rise_cyc <= cyc;
      valid_prev <= rx_valid;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
      rx_in = 1'b0;
      tick(CYCLE);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         tick(CYCLE);
      end
      rx_in = stop;
      tick(stop_len);
      rx_in = 1'b1;
   endtask

   // Model of one good frame: a consumer with ready held high drains at once.
   // Otherwise the byte fills an empty holder or is lost as an overrun.
   task automatic model_good(input logic [7:0] b, input logic ready_held, inout int exp_ov);
      if (ready_held) begin
         exp_q.push_back(b);
      end else if (!model_valid) begin
         model_valid = 1'b1;
         model_data  = b;
      end else begin
         exp_ov++;
      end
   endtask

   task automatic drain_check(input string tag);
      logic [7:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_present"}, 32'(got_q.size() > rd_idx), 32'd1);
         if (got_q.size() > rd_idx) begin
            check({tag, "_data"}, 32'(got_q[rd_idx]), 32'(e));
            rd_idx++;
         end
      end
      check({tag, "_no_extra"}, 32'(got_q.size()), 32'(rd_idx));
   endtask

   initial begin
      int         start_cyc;
      int         fe_base;
      int         ov_base;
      int         v_base;
      int         exp_ov;
      int         nbytes;
      logic [7:0] b;
      logic [7:0] fixed_bytes [3];

      reset_n  = 1'b0;
      rx_in    = 1'b1;
      rx_ready = 1'b0;
      tick(3);
      check("reset_data",  32'(rx_data),   32'h00);
      check("reset_valid", 32'(rx_valid),  32'd0);
      check("reset_busy",  32'(rx_busy),   32'd0);
      check("reset_fe",    32'(frame_err), 32'd0);
      check("reset_ov",    32'(overrun),   32'd0);
      reset_n = 1'b1;
      tick(5);

      // 1) Single byte A5 with the consumer always ready
      rx_ready = 1'b1;
      fe_base = fe_cnt; ov_base = ov_cnt; v_base = vcyc; exp_ov = 0;
      model_good(8'hA5, 1'b1, exp_ov);
      start_cyc = cyc;
      send_frame(8'hA5, 1'b1, CYCLE);
      tick(20);
      check("t1_latency", 32'(rise_cyc - start_cyc), 32'(LATENCY));
      check("t1_vcycles", 32'(vcyc - v_base), 32'd1);
      check("t1_fe", 32'(fe_cnt - fe_base), 32'd0);
      check("t1_ov", 32'(ov_cnt - ov_base), 32'(exp_ov));
      check("t1_valid_low", 32'(rx_valid), 32'd0);
      drain_check("t1");

      // 2) Start glitch of 5 clocks is rejected without output
      fe_base = fe_cnt; v_base = vcyc;
      rx_in = 1'b0;
      tick(5);
      check("t2_busy_high", 32'(rx_busy), 32'd1);
      rx_in = 1'b1;
      tick(HALF + 10);
      check("t2_busy_low", 32'(rx_busy), 32'd0);
      check("t2_valid", 32'(vcyc - v_base), 32'd0);
      check("t2_fe", 32'(fe_cnt - fe_base), 32'd0);
      drain_check("t2");

      // 3) Framing error followed by a held-low line (break)
      fe_base = fe_cnt; v_base = vcyc;
      send_frame(8'h3C, 1'b0, CYCLE + 100);
      rx_in = 1'b0;
      check("t3_busy_in_break", 32'(rx_busy), 32'd1);
      check("t3_fe_pulse", 32'(fe_cnt - fe_base), 32'd1);
      rx_in = 1'b1;
      tick(5);
      check("t3_busy_released", 32'(rx_busy), 32'd0);
      tick(CYCLE * 11);
      check("t3_fe_once", 32'(fe_cnt - fe_base), 32'd1);
      check("t3_no_valid", 32'(vcyc - v_base), 32'd0);
      check("t3_idle", 32'(rx_busy), 32'd0);
      drain_check("t3");

      // 4) Overrun: two back-to-back bytes while the consumer is not ready
      rx_ready = 1'b0;
      fe_base = fe_cnt; ov_base = ov_cnt; exp_ov = 0;
      model_good(8'h11, 1'b0, exp_ov);
      send_frame(8'h11, 1'b1, CYCLE);
      model_good(8'h22, 1'b0, exp_ov);
      send_frame(8'h22, 1'b1, CYCLE);
      tick(20);
      check("t4_valid_held", 32'(rx_valid), 32'(model_valid));
      check("t4_data", 32'(rx_data), 32'(model_data));
      check("t4_ov", 32'(ov_cnt - ov_base), 32'(exp_ov));
      check("t4_fe", 32'(fe_cnt - fe_base), 32'd0);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      exp_q.push_back(model_data);
      model_valid = 1'b0;
      check("t4_valid_cleared", 32'(rx_valid), 32'(model_valid));
      drain_check("t4");

      // 5) Random bytes with random idle gaps, then a continuous 00/FF/55 stream
      rx_ready = 1'b1;
      fe_base = fe_cnt; ov_base = ov_cnt; v_base = vcyc; exp_ov = 0;
      nbytes = 0;
      for (int k = 0; k < 6; k++) begin
         b = 8'($urandom);
         tick(int'($urandom_range(0, 40)));
         model_good(b, 1'b1, exp_ov);
         send_frame(b, 1'b1, CYCLE);
         nbytes++;
      end
      fixed_bytes[0] = 8'h00;
      fixed_bytes[1] = 8'hFF;
      fixed_bytes[2] = 8'h55;
      for (int k = 0; k < 3; k++) begin
         model_good(fixed_bytes[k], 1'b1, exp_ov);
         send_frame(fixed_bytes[k], 1'b1, CYCLE);
         nbytes++;
      end
      tick(20);
      check("t5_vcycles", 32'(vcyc - v_base), 32'(nbytes));
      check("t5_fe", 32'(fe_cnt - fe_base), 32'd0);
      check("t5_ov", 32'(ov_cnt - ov_base), 32'(exp_ov));
      check("t5_last_data", 32'(rx_data), 32'h55);
      drain_check("t5");

      // 6) Reset in the middle of bit 4 of C3, then a clean 7E
      rx_in = 1'b0;
      tick(CYCLE);
      for (int i = 0; i < 4; i++) begin
         b = 8'hC3;
         rx_in = b[i];
         tick(CYCLE);
      end
      b = 8'hC3;
      rx_in = b[4];
      tick(10);
      check("t6_busy_before", 32'(rx_busy), 32'd1);
      reset_n = 1'b0;
      tick(2);
      check("t6_rst_data",  32'(rx_data),   32'h00);
      check("t6_rst_valid", 32'(rx_valid),  32'd0);
      check("t6_rst_busy",  32'(rx_busy),   32'd0);
      check("t6_rst_fe",    32'(frame_err), 32'd0);
      check("t6_rst_ov",    32'(overrun),   32'd0);
      rx_in = 1'b1;
      tick(1);
      reset_n = 1'b1;
      tick(2 * CYCLE);
      check("t6_idle_after", 32'(rx_busy), 32'd0);
      v_base = vcyc; exp_ov = 0;
      model_good(8'h7E, 1'b1, exp_ov);
      send_frame(8'h7E, 1'b1, CYCLE);
      tick(20);
      check("t6_vcycles", 32'(vcyc - v_base), 32'd1);
      drain_check("t6");

      check("never_both_pulses", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
